// File: rtl/md5_search_ctrl_if.sv
// Message-block / digest channel between the search controller and the
// pipelined MD5 core.
interface md5_search_ctrl_if;
   logic         md_valid;
   logic [511:0] md_block;
   logic         dg_valid;
   logic [31:0]  dg_a;

   modport master (output md_valid, output md_block, input dg_valid, input dg_a);
   modport slave  (input md_valid, input md_block, output dg_valid, output dg_a);
endinterface

// File: rtl/md5_search_ctrl.sv
// AoC 2015 day 4 search controller: streams key+decimal candidate blocks into a
// fully pipelined MD5 core and reports the lowest candidate whose digest matches.
module md5_search_ctrl #(
   parameter int KEY_MAX_BYTES = 16,
   parameter int DIGITS        = 8,
   parameter int ZERO_NIBBLES  = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 key_wr,
   input  logic [7:0]           key_byte,
   input  logic                 key_clear,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 found,
   output logic [31:0]          answer,
   md5_search_ctrl_if.master    core
);

   localparam int KLW = $clog2(KEY_MAX_BYTES + 1);
   localparam int NDW = $clog2(DIGITS + 2);
   localparam int BW  = 4 * DIGITS;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e                       state_q, state_d;
   logic [8*KEY_MAX_BYTES-1:0]   key_q, key_d;
   logic [KLW-1:0]               key_len_q, key_len_d;
   logic [BW-1:0]                bcd_q, bcd_d;
   logic [NDW-1:0]               ndig_q, ndig_d;
   logic [31:0]                  cnt_q, cnt_d;
   logic [31:0]                  infl_q, infl_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;
   logic                         found_q, found_d;
   logic [31:0]                  answer_q, answer_d;
   logic                         md_valid_q, md_valid_d;
   logic [511:0]                 md_block_q, md_block_d;

   logic                         idle_like, active, dg_take, hit, issue, last, nines;
   logic [BW-1:0]                cur_bcd;
   logic [NDW-1:0]               cur_nd;

   // Nibble k of the digest lives in byte k/2, high half first.
   function automatic logic zero_prefix(input logic [31:0] w);
      logic z;
      z = 1'b1;
      for (int k = 0; k < ZERO_NIBBLES; k++) begin
         if (w[(k / 2) * 8 + ((k % 2 == 0) ? 4 : 0) +: 4] != 4'h0) z = 1'b0;
      end
      return z;
   endfunction

   function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic all_nines(input logic [BW-1:0] v, input logic [NDW-1:0] n);
      logic r;
      r = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (i < int'(n) && v[4*i +: 4] != 4'd9) r = 1'b0;
      end
      return r;
   endfunction

   function automatic logic [511:0] build_block(input logic [8*KEY_MAX_BYTES-1:0] key,
                                                input logic [KLW-1:0]             klen,
                                                input logic [BW-1:0]              bcd,
                                                input logic [NDW-1:0]             nd);
      logic [511:0] b;
      int           kl;
      int           n;
      int           tot;
      b   = '0;
      kl  = int'(klen);
      n   = int'(nd);
      tot = kl + n;
      for (int j = 0; j < KEY_MAX_BYTES; j++) begin
         if (j < kl) b[8*j +: 8] = key[8*j +: 8];
      end
      // Digits go out most significant first; BCD digit 0 is the units digit.
      for (int d = 0; d < DIGITS; d++) begin
         if (d < n) b[8*(kl + d) +: 8] = {4'h3, bcd[4*(n - 1 - d) +: 4]};
      end
      b[8*tot +: 8]  = 8'h80;
      b[8*56 +: 16]  = 16'(8 * tot);
      return b;
   endfunction

   always_comb begin
      state_d    = state_q;
      key_d      = key_q;
      key_len_d  = key_len_q;
      bcd_d      = bcd_q;
      ndig_d     = ndig_q;
      cnt_d      = cnt_q;
      found_d    = found_q;
      answer_d   = answer_q;
      md_valid_d = 1'b0;
      md_block_d = md_block_q;
      issue      = 1'b0;
      cur_bcd    = bcd_q;
      cur_nd     = ndig_q;
      nines      = 1'b0;
      last       = 1'b0;

      idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
      active    = (state_q == S_RUN) || (state_q == S_DRAIN);
      dg_take   = active && core.dg_valid;
      hit       = dg_take && !found_q && zero_prefix(core.dg_a);

      if (idle_like) begin
         if (key_clear) begin
            key_len_d = '0;
         end else if (key_wr && key_len_q < KLW'(KEY_MAX_BYTES)) begin
            key_d[8*key_len_q +: 8] = key_byte;
            key_len_d               = key_len_q + 1'b1;
         end
      end

      // The start cycle already issues candidate 1 so it appears on the next cycle.
      if (idle_like && start) begin
         cur_bcd = BW'(1);
         cur_nd  = NDW'(1);
         issue   = 1'b1;
         cnt_d   = 32'd1;
         found_d = 1'b0;
      end else if (state_q == S_RUN && !hit) begin
         issue = 1'b1;
      end

      if (dg_take) cnt_d = cnt_q + 32'd1;
      if (hit) begin
         found_d  = 1'b1;
         answer_d = cnt_q;
      end

      if (issue) begin
         nines      = all_nines(cur_bcd, cur_nd);
         last       = nines && (cur_nd == NDW'(DIGITS));
         md_valid_d = 1'b1;
         md_block_d = build_block(key_q, key_len_q, cur_bcd, cur_nd);
         bcd_d      = bcd_inc(cur_bcd);
         ndig_d     = cur_nd + NDW'(nines);
      end

      infl_d = infl_q + 32'(issue) - 32'(dg_take);

      case (state_q)
         S_IDLE, S_DONE: if (start) state_d = S_RUN;
         S_RUN:          if (hit || last) state_d = (infl_d == 32'd0) ? S_DONE : S_DRAIN;
         S_DRAIN:        if (infl_d == 32'd0) state_d = S_DONE;
         default:        state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      key_q <= key_d;
      if (reset) begin
         state_q    <= S_IDLE;
         key_len_q  <= '0;
         bcd_q      <= '0;
         ndig_q     <= '0;
         cnt_q      <= '0;
         infl_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         found_q    <= 1'b0;
         answer_q   <= '0;
         md_valid_q <= 1'b0;
         md_block_q <= '0;
      end else begin
         state_q    <= state_d;
         key_len_q  <= key_len_d;
         bcd_q      <= bcd_d;
         ndig_q     <= ndig_d;
         cnt_q      <= cnt_d;
         infl_q     <= infl_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         found_q    <= found_d;
         answer_q   <= answer_d;
         md_valid_q <= md_valid_d;
         md_block_q <= md_block_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign found         = found_q;
   assign answer        = answer_q;
   assign core.md_valid = md_valid_q;
   assign core.md_block = md_block_q;

endmodule

// File: doc/md5_search_ctrl.md
# md5_search_ctrl

Search controller for the AoC 2015 day 4 MD5 pipeline. Holds the secret key, generates candidate numbers 1, 2, 3, … as decimal ASCII, builds one padded 512-bit message block per cycle for the fully pipelined MD5 core, and checks the returned digests in order for the required run of leading zero hex digits. Reports the first (lowest) matching number and drains the pipeline before accepting a new search.

## Interface

- KEY_MAX_BYTES, 16: key buffer capacity in bytes.
- DIGITS, 8: maximum decimal digits of the candidate; KEY_MAX_BYTES + DIGITS <= 55.
- ZERO_NIBBLES, 5: leading zero hex digits required, 1..8.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- key_wr  in  1  append key_byte to key buffer.
- key_byte  in  8  key character (ASCII).
- key_clear  in  1  empty key buffer.
- start  in  1  begin search (pulse).
- busy  out  1  search or drain in progress.
- done  out  1  search finished; level, held until next start.
- found  out  1  valid with done; 1 = match found.
- answer  out  32  lowest matching number (binary); valid when done && found.
- md_valid  out  1  md_block valid this cycle.
- md_block  out  512  message block; message byte j at bits [8j+7:8j].
- dg_valid  in  1  digest word valid (in issue order, no backpressure).
- dg_a  in  32  final digest word A (IV already added); hex digit 0 is dg_a[7:4].

## Operation

- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE: key_wr appends byte at index key_len, key_len++; ignored when key_len == KEY_MAX_BYTES. key_clear sets key_len = 0; key_clear wins over key_wr in the same cycle. key_wr/key_clear ignored in RUN/DRAIN.
- start in IDLE/DONE: BCD candidate = 1, ndig = 1, result counter = 1, found = 0, done = 0 -> RUN. start in RUN/DRAIN ignored.
- RUN: md_valid = 1 every cycle. Block bytes: key[0..key_len-1], then ndig ASCII digits (most significant first, no leading zeros), then 0x80, zeros to byte 55, bytes 56..63 = 64-bit little-endian bit length 8*(key_len+ndig). Candidate increments in BCD after each issue; on all-nines rollover ndig++.
- Issuing the candidate 10^DIGITS − 1 is the last issue -> DRAIN (found stays 0 unless a digest matches).
- Digest check: each dg_valid increments the binary result counter; match = nibbles 0..ZERO_NIBBLES−1 all zero, nibble k = byte k/2, upper half for even k. First match while found == 0 latches answer = result counter, found = 1; later digests never overwrite.
- Match in RUN: stop issuing from the next cycle -> DRAIN.
- In-flight counter: +1 per issue, −1 per dg_valid, both same cycle = no change. DRAIN: md_valid = 0, digests still checked while found == 0; in-flight == 0 -> DONE, done = 1.
- busy = 1 in RUN and DRAIN.

## Timing

- Reset: state IDLE, key_len 0, busy/done/found/md_valid 0, answer 0, in-flight 0. Reset mid-search aborts immediately; the MD5 core shares the same reset so no stale digests return.
- start registered in cycle t -> md_valid = 1 with candidate 1 in cycle t+1.
- All outputs registered. dg_valid match in cycle t -> found/answer visible cycle t+1; md_valid 0 from cycle t+1.
- Last dg_valid in cycle t (in-flight reaching 0) -> done = 1, busy = 0 in cycle t+1.
- Throughput: one block per cycle, no bubbles, in RUN.

## Test plan

- Format (stub core): key "abc", start -> first md_block bytes 0..3 = "abc1", byte 4 = 0x80, byte 56 = 0x20, others 0; candidate 10 gives "abc10", 0x80 at byte 5, byte 56 = 0x28.
- Real MD5 core, ZERO_NIBBLES=5: key "abcdef" -> done, found = 1, answer = 609043; key "pqrstuv" -> answer = 1048970.
- Stub core fixed latency 32, forced match on 3rd and 5th digest -> answer = 3, md_valid drops the cycle after, done asserts after in-flight drains, later match ignored.
- DIGITS=2, stub never matching -> exactly 99 issues, done = 1, found = 0; match forced on digest 99 during DRAIN -> found = 1, answer = 99.
- reset asserted mid-RUN -> next cycle all outputs 0, key_len 0; fresh key load + start gives candidate 1.
- key_wr with 17 bytes -> only first 16 kept; key_wr and start during RUN ignored; restart from DONE works without reset.
